dvi_link_ctrl: RTL

- Power-up and recovery sequencer for the DVI transmit datapath. It runs on the pixel clock.
- Waits for MMCM lock, lets the clocks settle, pulses the serializer reset and releases the video timing generator.
- Forces black for a set number of whole frames, then enables video on a frame boundary.
- Tears the link down cleanly on lock loss or when disabled, and feeds the reset/enable inputs of the timing, pattern and rgb-to-dvi blocks.

---
 rtl/dvi_pkg.sv | 19 +
 rtl/dvi_sync2.sv | 24 ++
 rtl/dvi_link_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dvi_pkg.sv
// Shared constants for the DVI transmit link sequencer: state encoding and
// the default video timing that sizes the vsync watchdog.
package dvi_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_SERDES_RST = 3'd2,
        ST_BLANK      = 3'd3,
        ST_ACTIVE     = 3'd4,
        ST_DRAIN      = 3'd5
    } state_t;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    // Two full frames without a vsync means the timing generator is stuck.
    localparam int WDT_DEFAULT_CYCLES = 2 * H_TOTAL * V_TOTAL;

endpackage

// File: rtl/dvi_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the i_clk domain.
module dvi_sync2 (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dvi_link_ctrl.sv
// Power-up / recovery sequencer for the DVI transmit path on the pixel clock.
// Define DVI_LINK_CTRL_WATCHDOG_EN to add the vsync watchdog re-sequencing.
//
// state      | meaning
// WAIT_LOCK  | serializers and timing held in reset, waiting for lock + enable
// SETTLE     | lock seen, letting clocks settle
// SERDES_RST | serializer reset pulse, timing still held
// BLANK      | timing running, video forced black for whole frames
// ACTIVE     | link up, video passing
// DRAIN      | disable requested, video kept until the frame ends
module dvi_link_ctrl
    import dvi_pkg::*;
#(
    parameter int LOCK_SETTLE_CYCLES = 1024,
    parameter int SERDES_RST_CYCLES  = 16,
    parameter int BLANK_FRAMES       = 2,
    parameter int WDT_CYCLES         = WDT_DEFAULT_CYCLES,
    parameter int CNT_W              = 20
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_locked,
    input  logic       i_enable,
    input  logic       i_vsync,
    output logic       o_serdes_rst,
    output logic       o_timing_rst,
    output logic       o_video_en,
    output logic       o_link_up,
    output logic [2:0] o_state,
    output logic [7:0] o_lock_loss_cnt,
    output logic       o_wdt_trip
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_vsync_d;
    logic               w_vs_rise;
    logic               w_locked_s;
    logic               w_lock_loss;
    logic               r_serdes_rst;
    logic               r_timing_rst;
    logic               r_video_en;
    logic               r_link_up;
    logic [7:0]         r_lock_loss_cnt;

    dvi_sync2 u_lock_sync (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_d    (i_locked),
        .o_q    (w_locked_s)
    );

    assign w_vs_rise = i_vsync & ~r_vsync_d;

`ifdef DVI_LINK_CTRL_WATCHDOG_EN
    logic [CNT_W-1:0]   r_wdt_cnt;
    logic               r_wdt_trip;
    logic               w_wdt_hit;
    logic               w_vid_state;
    logic               w_vid_nxt;

    assign w_vid_state = (r_state inside {ST_BLANK, ST_ACTIVE, ST_DRAIN});
    assign w_vid_nxt   = (w_state_nxt inside {ST_BLANK, ST_ACTIVE, ST_DRAIN});
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_lock_loss = 1'b0;
        case (r_state)
            ST_WAIT_LOCK:
                if (w_locked_s && i_enable) w_state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (!i_enable) w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == CNT_W'(LOCK_SETTLE_CYCLES - 1)) w_state_nxt = ST_SERDES_RST;
            ST_SERDES_RST:
                if (r_cnt == CNT_W'(SERDES_RST_CYCLES - 1)) w_state_nxt = ST_BLANK;
            ST_BLANK:
                if (!i_enable) w_state_nxt = ST_WAIT_LOCK;
                else if (w_vs_rise && r_cnt == CNT_W'(BLANK_FRAMES - 1)) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE:
                if (!i_enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (i_enable) w_state_nxt = ST_ACTIVE;
                else if (w_vs_rise) w_state_nxt = ST_WAIT_LOCK;
            default:
                w_state_nxt = ST_WAIT_LOCK;
        endcase
`ifdef DVI_LINK_CTRL_WATCHDOG_EN
        w_wdt_hit = 1'b0;
        if (w_vid_state && r_wdt_cnt == CNT_W'(WDT_CYCLES - 1)) begin
            w_wdt_hit   = 1'b1;
            w_state_nxt = ST_SERDES_RST;
        end
`endif
        // Lock loss overrides every other transition, including the watchdog.
        if (r_state != ST_WAIT_LOCK && !w_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_lock_loss = 1'b1;
`ifdef DVI_LINK_CTRL_WATCHDOG_EN
            w_wdt_hit   = 1'b0;
`endif
        end
        w_cnt_nxt = '0;
        if (w_state_nxt == r_state) begin
            case (r_state)
                ST_SETTLE, ST_SERDES_RST: w_cnt_nxt = r_cnt + CNT_W'(1);
                ST_BLANK:                 w_cnt_nxt = r_cnt + CNT_W'(w_vs_rise);
                default:                  w_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= '0;
            r_vsync_d       <= 1'b0;
            r_serdes_rst    <= 1'b1;
            r_timing_rst    <= 1'b1;
            r_video_en      <= 1'b0;
            r_link_up       <= 1'b0;
            r_lock_loss_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_vsync_d    <= i_vsync;
            r_serdes_rst <= (w_state_nxt inside {ST_WAIT_LOCK, ST_SETTLE, ST_SERDES_RST});
            r_timing_rst <= (w_state_nxt inside {ST_WAIT_LOCK, ST_SETTLE, ST_SERDES_RST});
            r_video_en   <= (w_state_nxt inside {ST_ACTIVE, ST_DRAIN});
            r_link_up    <= (w_state_nxt == ST_ACTIVE);
            if (w_lock_loss && r_lock_loss_cnt != 8'hFF)
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

`ifdef DVI_LINK_CTRL_WATCHDOG_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_wdt_cnt  <= '0;
            r_wdt_trip <= 1'b0;
        end else begin
            r_wdt_trip <= w_wdt_hit;
            if (!w_vid_nxt || w_state_nxt != r_state || w_vs_rise)
                r_wdt_cnt <= '0;
            else
                r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
        end
    end

    assign o_wdt_trip = r_wdt_trip;
`else
    // Constant low; WDT_CYCLES only matters when the watchdog is built in.
    assign o_wdt_trip = (WDT_CYCLES < 0);
`endif

    assign o_serdes_rst    = r_serdes_rst;
    assign o_timing_rst    = r_timing_rst;
    assign o_video_en      = r_video_en;
    assign o_link_up       = r_link_up;
    assign o_state         = r_state;
    assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule
